// File: rtl/gyro_bias_calibrator.sv
// Zero-rate bias estimator and corrector feeding the gyro integrator; 1-cycle latency, no backpressure.
// Optional GYRO_CAL_DEADBAND_EN zeroes corrected axes whose magnitude is within DEADBAND.
module gyro_bias_calibrator #(
    parameter int LOG2_SAMPLES = 8,
    parameter int DEADBAND     = 16
) (
    input  logic               clk_100mhz,
    input  logic               rst_in,
    input  logic               raw_valid,
    input  logic signed [15:0] raw_gx,
    input  logic signed [15:0] raw_gy,
    input  logic signed [15:0] raw_gz,
    input  logic               cal_start,
    output logic signed [15:0] gx,
    output logic signed [15:0] gy,
    output logic signed [15:0] gz,
    output logic               out_valid,
    output logic               calibrated,
    output logic signed [15:0] bias_x,
    output logic signed [15:0] bias_y,
    output logic signed [15:0] bias_z
);

    localparam int AW = 16 + LOG2_SAMPLES;

    if (LOG2_SAMPLES < 1 || LOG2_SAMPLES > 12 || DEADBAND < 0) begin : g_param_check
        $error("gyro_bias_calibrator: illegal parameter value");
    end

    typedef enum logic [1:0] {CAL, LATCH, RUN} state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [LOG2_SAMPLES-1:0] cnt;
    logic signed [AW-1:0]    acc_x;
    logic signed [AW-1:0]    acc_y;
    logic signed [AW-1:0]    acc_z;
    logic signed [15:0]      corr_x;
    logic signed [15:0]      corr_y;
    logic signed [15:0]      corr_z;
    logic                    last_sample;

    function automatic logic signed [AW-1:0] sext(input logic signed [15:0] v);
        return {{LOG2_SAMPLES{v[15]}}, v};
    endfunction

    function automatic logic signed [15:0] correct(input logic signed [15:0] raw,
                                                   input logic signed [15:0] bias);
        logic signed [16:0] diff;
        logic signed [15:0] sat;
`ifdef GYRO_CAL_DEADBAND_EN
        logic [16:0] mag;
`endif
        diff = {raw[15], raw} - {bias[15], bias};
        if (diff[16] != diff[15]) begin
            sat = diff[16] ? 16'sh8000 : 16'sh7fff;
        end else begin
            sat = diff[15:0];
        end
`ifdef GYRO_CAL_DEADBAND_EN
        // 17-bit magnitude so that -32768 maps to 32768 rather than wrapping
        mag = sat[15] ? -{sat[15], sat} : {1'b0, sat};
        if (mag <= 17'(DEADBAND)) begin
            sat = '0;
        end
`endif
        return sat;
    endfunction

    assign corr_x      = correct(raw_gx, bias_x);
    assign corr_y      = correct(raw_gy, bias_y);
    assign corr_z      = correct(raw_gz, bias_z);
    assign last_sample = raw_valid && (cnt == {LOG2_SAMPLES{1'b1}});

    always_comb begin
        state_nx = state;
        case (state)
            CAL:     if (!cal_start && last_sample) state_nx = LATCH;
            LATCH:   state_nx = RUN;
            RUN:     if (cal_start) state_nx = CAL;
            default: state_nx = CAL;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state      <= CAL;
            cnt        <= '0;
            acc_x      <= '0;
            acc_y      <= '0;
            acc_z      <= '0;
            bias_x     <= '0;
            bias_y     <= '0;
            bias_z     <= '0;
            gx         <= '0;
            gy         <= '0;
            gz         <= '0;
            out_valid  <= 1'b0;
            calibrated <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            case (state)
                CAL: begin
                    gx <= '0;
                    gy <= '0;
                    gz <= '0;
                    if (cal_start) begin
                        cnt   <= '0;
                        acc_x <= '0;
                        acc_y <= '0;
                        acc_z <= '0;
                    end else if (raw_valid) begin
                        cnt   <= cnt + 1'b1;
                        acc_x <= acc_x + sext(raw_gx);
                        acc_y <= acc_y + sext(raw_gy);
                        acc_z <= acc_z + sext(raw_gz);
                    end
                end
                LATCH: begin
                    // arithmetic shift floors toward minus infinity
                    bias_x     <= 16'(acc_x >>> LOG2_SAMPLES);
                    bias_y     <= 16'(acc_y >>> LOG2_SAMPLES);
                    bias_z     <= 16'(acc_z >>> LOG2_SAMPLES);
                    cnt        <= '0;
                    acc_x      <= '0;
                    acc_y      <= '0;
                    acc_z      <= '0;
                    calibrated <= 1'b1;
                end
                RUN: begin
                    if (cal_start) begin
                        calibrated <= 1'b0;
                        gx         <= '0;
                        gy         <= '0;
                        gz         <= '0;
                    end else if (raw_valid) begin
                        gx        <= corr_x;
                        gy        <= corr_y;
                        gz        <= corr_z;
                        out_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
